// File: rtl/jelly_bean_taster.sv
// Jelly-bean taster: samples one bean per cycle and returns a registered verdict
// one cycle later. It tracks same-flavour streaks (palate fatigue) and keeps
// saturating yummy/yucky statistics.
module jelly_bean_taster #(
  parameter int FATIGUE_LEN = 4,   // streak length that turns the verdict YUCKY, 2..15
  parameter int CNT_W       = 16   // width of each statistics counter
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       flavor,
  input  logic [1:0]       color,
  input  logic             sugar_free,
  input  logic             sour,
  input  logic             stats_clr,
  output logic [1:0]       taste,
  output logic [CNT_W-1:0] yummy_cnt,
  output logic [CNT_W-1:0] yucky_cnt,
  output logic             fatigued
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRESH = 2'd1,
    TIRED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    YUMMY   = 2'd1,
    YUCKY   = 2'd2
  } taste_t;

  localparam logic [2:0] CHOCOLATE = 3'd4;
  localparam logic [3:0] FAT_LEN   = 4'(FATIGUE_LEN);

  state_t           state_q, state_d;
  taste_t           taste_q, verdict;
  logic [3:0]       streak_q, streak_d;
  logic [2:0]       last_q, last_d;
  logic [CNT_W-1:0] yummy_q, yummy_d;
  logic [CNT_W-1:0] yucky_q, yucky_d;
  logic             bean;
  logic             same_flavor;

  // Colour is informational only; it never reaches the verdict.
  logic unused_color;
  assign unused_color = ^color;

  // State register for the palate FSM.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // the pre-edge values of its neighbours; blocking here would create races.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Streak update, verdict, next state and counter next values.
  // NOTE: every signal written here gets a default first, so no path through
  // the ifs/case leaves one unassigned and no latch is inferred.
  always_comb begin
    bean        = (flavor != 3'd0) && (flavor <= CHOCOLATE);
    same_flavor = (flavor == last_q);
    streak_d    = streak_q;
    last_d      = last_q;
    verdict     = UNKNOWN;
    state_d     = state_q;
    yummy_d     = yummy_q;
    yucky_d     = yucky_q;

    if (bean) begin
      // Streak saturates at FATIGUE_LEN; a new flavour restarts it at 1.
      if (same_flavor) begin
        streak_d = (streak_q >= FAT_LEN) ? FAT_LEN : streak_q + 4'd1;
      end else begin
        streak_d = 4'd1;
        last_d   = flavor;
      end

      if (flavor == CHOCOLATE && sour)  verdict = YUCKY;
      else if (sugar_free && sour)      verdict = YUCKY;
      else if (streak_d >= FAT_LEN)     verdict = YUCKY;
      else                              verdict = YUMMY;

      case (state_q)
        IDLE:    state_d = (streak_d >= FAT_LEN) ? TIRED : FRESH;
        FRESH:   if (streak_d >= FAT_LEN) state_d = TIRED;
        TIRED:   if (!same_flavor) state_d = FRESH;
        default: state_d = IDLE;
      endcase

      if (verdict == YUMMY && yummy_q != '1) yummy_d = yummy_q + 1'b1;
      if (verdict == YUCKY && yucky_q != '1) yucky_d = yucky_q + 1'b1;
    end

    // Clearing wins over a same-cycle increment: that bean is not counted.
    if (stats_clr) begin
      yummy_d = '0;
      yucky_d = '0;
    end
  end

  // Datapath registers: verdict, streak tracking and statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taste_q  <= UNKNOWN;
      streak_q <= 4'd0;
      last_q   <= 3'd0;
      yummy_q  <= '0;
      yucky_q  <= '0;
    end else begin
      taste_q  <= verdict;
      streak_q <= streak_d;
      last_q   <= last_d;
      yummy_q  <= yummy_d;
      yucky_q  <= yucky_d;
    end
  end

  assign taste     = taste_q;
  assign yummy_cnt = yummy_q;
  assign yucky_cnt = yucky_q;
  assign fatigued  = (state_q == TIRED);

endmodule

// File: doc/jelly_bean_taster.md
Name: jelly_bean_taster

Overview:
- Taster DUT on the slave side of the jelly-bean interface.
- Each cycle it samples the bean attributes driven by the master (flavor, color, sugar_free, sour) and returns a registered taste verdict one cycle later.
- Tracks palate fatigue: consecutive identical flavours are eventually rejected.
- Keeps saturating yummy/yucky statistics for scoreboard cross-checking.

Parameters:
- FATIGUE_LEN, 4: number of consecutive identical-flavour beans at which the verdict turns YUCKY; legal range 2..15.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- flavor  input  3  0 NO_FLAVOR, 1 APPLE, 2 BLUEBERRY, 3 BUBBLE_GUM, 4 CHOCOLATE, 5-7 illegal.
- color  input  2  0 RED, 1 GREEN, 2 BLUE, 3 illegal; informational only.
- sugar_free  input  1  bean is sugar-free.
- sour  input  1  bean is sour.
- stats_clr  input  1  synchronous clear of both counters.
- taste  output  2  0 UNKNOWN, 1 YUMMY, 2 YUCKY; 3 never driven.
- yummy_cnt  output  CNT_W  count of YUMMY verdicts.
- yucky_cnt  output  CNT_W  count of YUCKY verdicts.
- fatigued  output  1  high while in TIRED state.

Behaviour:
- Reset (rst_n=0 at posedge):
  - taste=0, yummy_cnt=0, yucky_cnt=0, fatigued=0.
  - streak=0, last_flavor=0, state=IDLE.
  - Reset overrides all other inputs, including mid-streak.
- Bean cycle: any cycle with flavor in 1..4. Idle cycle: flavor 0 or 5-7.
- Latency: inputs sampled at posedge N; taste valid after posedge N and sampled by the master clocking block at posedge N+1.
- Idle cycle handling:
  - taste<=UNKNOWN.
  - streak, last_flavor and state unchanged; idle cycles do not break a streak.
  - Counters unchanged.
- Streak update on a bean cycle:
  - flavor==last_flavor: streak<=min(streak+1, FATIGUE_LEN).
  - Otherwise: streak<=1 and last_flavor<=flavor.
  - new_streak is the post-update value and is used in the verdict below.
- Verdict on a bean cycle, in priority order:
  1. CHOCOLATE && sour -> YUCKY.
  2. sugar_free && sour -> YUCKY.
  3. new_streak>=FATIGUE_LEN -> YUCKY.
  4. Otherwise -> YUMMY.
  - color never affects the verdict.
- FSM, updated on bean cycles only:
  - IDLE -> FRESH on the first bean after reset.
  - FRESH -> TIRED when new_streak reaches FATIGUE_LEN.
  - TIRED -> FRESH when a different flavour arrives (streak restarts at 1).
  - fatigued = (state==TIRED), registered, updating in the same cycle as taste.
- Counters:
  - On a bean cycle, the counter matching the verdict increments, saturating at 2^CNT_W-1.
  - stats_clr=1 zeroes both counters; it takes precedence over a same-cycle increment, so that bean is not counted.
  - taste is still produced normally for that bean.
  - stats_clr does not affect streak, state or taste.
- Illegal flavour (5-7) is treated exactly as idle. Illegal color is ignored.
- No X propagation: with known inputs, every output is known one cycle after reset.

Test Plan:
- Reset then APPLE, not sour, not sugar_free, 1 cycle -> taste=1 one cycle later, yummy_cnt=1, yucky_cnt=0, fatigued=0.
- CHOCOLATE+sour -> taste=2; CHOCOLATE not sour -> taste=1; BLUEBERRY+sugar_free+sour -> taste=2; yucky_cnt=2, yummy_cnt=1.
- FATIGUE_LEN=4, APPLE x5 with idle (flavor=0) cycles interleaved:
  - tastes 1,1,1,2,2; fatigued rises with the 4th bean.
  - idle cycles give taste=0 and do not reset the streak.
  - Then BUBBLE_GUM -> taste=1, fatigued=0.
- stats_clr asserted in the same cycle as a YUMMY bean after 3 prior YUMMYs -> taste=1, yummy_cnt=0 next cycle; next YUMMY gives yummy_cnt=1.
- CNT_W=2, 5 YUMMY beans of alternating flavours -> yummy_cnt saturates at 3, no wrap.
- rst_n low for one cycle after 3 consecutive GREEN APPLE beans, then APPLE -> taste=1 (streak restarted), all counters restart from 0; flavor=6 -> taste=0, no counter change.
